mdu: RTL and testbench

- Multiply/divide unit for the Execute stage of the 5-stage MIPS pipeline.
- Driven by the decoder's start, MDUOp, HIWrite and LOWrite signals, with operands taken from the forwarded rs/rt values in E.
- Holds the architectural HI and LO registers and exposes them for mfhi/mflo write-back selection.
- Reports busy so the hazard unit can stall MD-class instructions in D.

---
 rtl/mdu_pkg.sv | 24 ++
 rtl/mdu.sv | 123 ++++++++++++
 tb/tb_mdu.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: MDUOp encodings, FSM states
// and the pending-result payload.
package mdu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] MDU_MULTU = 3'b000;
  localparam logic [2:0] MDU_MULT  = 3'b001;
  localparam logic [2:0] MDU_DIVU  = 3'b010;
  localparam logic [2:0] MDU_DIV   = 3'b011;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  // skip marks a divide by zero: the busy sequence runs but HI/LO are kept
  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic            skip;
  } result_t;

endpackage

// File: rtl/mdu.sv
// Execute-stage multiply/divide unit: computes the result at start, holds it
// pending for a fixed latency, then commits it to the HI/LO registers.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDUOp,
  input  logic        HIWrite,
  input  logic        LOWrite,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  result_t            pend, pend_n;
  logic [XLEN-1:0]    hi_q, hi_n, lo_q, lo_n;

  logic [63:0]        prod_u, prod_s;
  logic [XLEN-1:0]    div_b, quo_u, rem_u;
  logic signed [32:0] sa, sb, sq, sr;
  result_t            res;
  logic               op_valid;

  // Arithmetic datapath; a zero divisor is replaced by 1 so no X reaches the pending regs
  always_comb begin
    prod_u = {32'b0, A} * {32'b0, B};
    prod_s = 64'($signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B}));
    div_b  = (B == 32'd0) ? 32'd1 : B;
    quo_u  = A / div_b;
    rem_u  = A % div_b;
    // 33-bit signed divide keeps 0x80000000 / -1 from overflowing
    sa     = {A[31], A};
    sb     = {div_b[31], div_b};
    sq     = sa / sb;
    sr     = sa % sb;
    op_valid = 1'b1;
    res      = '0;
    case (MDUOp)
      MDU_MULTU: res = '{hi: prod_u[63:32], lo: prod_u[31:0], skip: 1'b0};
      MDU_MULT:  res = '{hi: prod_s[63:32], lo: prod_s[31:0], skip: 1'b0};
      MDU_DIVU:  res = '{hi: rem_u, lo: quo_u, skip: (B == 32'd0)};
      MDU_DIV:   res = '{hi: sr[31:0], lo: sq[31:0], skip: (B == 32'd0)};
      default:   op_valid = 1'b0;
    endcase
  end

  // Next-state logic: launch, countdown/commit, and mthi/mtlo when idle
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pend_n  = pend;
    hi_n    = hi_q;
    lo_n    = lo_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (op_valid) begin
            pend_n  = res;
            cnt_n   = MDUOp[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            state_n = S_BUSY;
          end
        end else begin
          if (HIWrite) hi_n = A;
          if (LOWrite) lo_n = A;
        end
      end
      S_BUSY: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_n = S_IDLE;
          if (!pend.skip) begin
            hi_n = pend.hi;
            lo_n = pend.lo;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      pend  <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      pend  <= pend_n;
      hi_q  <= hi_n;
      lo_q  <= lo_n;
    end
  end

  assign busy = (state == S_BUSY);
  assign HI   = hi_q;
  assign LO   = lo_q;

  // The hazard unit and decoder must never produce these combinations
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(busy && (start || HIWrite || LOWrite)))
        else $warning("mdu: start/HIWrite/LOWrite while busy, ignored");
      assert (!(start && (HIWrite || LOWrite)))
        else $warning("mdu: start together with HIWrite/LOWrite, writes dropped");
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu.
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  MDUOp;
  logic        HIWrite;
  logic        LOWrite;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks   = 0;
  int failures = 0;
  logic [31:0] cur_hi = 32'h0;
  logic [31:0] cur_lo = 32'h0;

  mdu dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .MDUOp   (MDUOp),
    .HIWrite (HIWrite),
    .LOWrite (LOWrite),
    .A       (A),
    .B       (B),
    .busy    (busy),
    .HI      (HI),
    .LO      (LO)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
  endtask

  // Pulse start, check busy for n cycles with HI/LO held, then check the commit
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n,
                        input logic [31:0] eh, input logic [31:0] el);
    A = a; B = b; MDUOp = op; start = 1'b1;
    tick();
    start = 1'b0; A = 32'h0; B = 32'h0;
    for (int i = 0; i < n; i++) begin
      check({tag, "_busy"}, 32'(busy), 32'd1);
      if (i == 0) begin
        check({tag, "_hold_hi"}, HI, cur_hi);
        check({tag, "_hold_lo"}, LO, cur_lo);
      end
      tick();
    end
    check({tag, "_done"}, 32'(busy), 32'd0);
    check({tag, "_hi"}, HI, eh);
    check({tag, "_lo"}, LO, el);
    cur_hi = eh;
    cur_lo = el;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; MDUOp = 3'b000;
    HIWrite = 1'b0; LOWrite = 1'b0; A = 32'h0; B = 32'h0;
    tick(); tick();
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", HI, 32'h0);
    check("rst_lo", LO, 32'h0);

    run_op("multu_7x6", 3'b000, 32'd7, 32'd6, 5, 32'h0, 32'd42);
    run_op("mult_m2x3", 3'b001, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu_m2x3", 3'b000, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA);
    run_op("div_m7_2", 3'b011, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu_7_2", 3'b010, 32'd7, 32'd2, 10, 32'd1, 32'd3);

    // mthi / mtlo preload
    A = 32'h1234; HIWrite = 1'b1;
    tick();
    HIWrite = 1'b0;
    check("mthi", HI, 32'h1234);
    A = 32'h5678; LOWrite = 1'b1;
    tick();
    LOWrite = 1'b0;
    check("mtlo", LO, 32'h5678);
    cur_hi = 32'h1234; cur_lo = 32'h5678;

    run_op("divu_by0", 3'b010, 32'd9, 32'd0, 10, 32'h1234, 32'h5678);
    run_op("div_ovf", 3'b011, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000);

    // Invalid opcode with start is ignored
    A = 32'd3; B = 32'd4; MDUOp = 3'b101; start = 1'b1;
    tick();
    start = 1'b0;
    check("inv_busy", 32'(busy), 32'd0);
    tick();
    check("inv_busy2", 32'(busy), 32'd0);
    check("inv_lo", LO, 32'h80000000);

    // Reset during busy cycle 3 discards the in-flight result
    A = 32'd5; B = 32'd5; MDUOp = 3'b001; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    check("rstmid_busy3", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_hi", HI, 32'h0);
    check("rstmid_lo", LO, 32'h0);
    for (int i = 0; i < 5; i++) tick();
    check("rstmid_late_busy", 32'(busy), 32'd0);
    check("rstmid_late_lo", LO, 32'h0);
    check("rstmid_late_hi", HI, 32'h0);

    // mtlo, then multu with an illegal HIWrite during busy cycle 2
    A = 32'hAAAA0000; LOWrite = 1'b1;
    tick();
    LOWrite = 1'b0;
    check("mtlo2", LO, 32'hAAAA0000);
    A = 32'd2; B = 32'd3; MDUOp = 3'b000; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    A = 32'hDEADBEEF; HIWrite = 1'b1;
    tick();
    HIWrite = 1'b0;
    check("hiw_busy_hi", HI, 32'h0);
    check("hiw_busy", 32'(busy), 32'd1);
    tick(); tick(); tick();
    check("hiw_done", 32'(busy), 32'd0);
    check("hiw_hi", HI, 32'h0);
    check("hiw_lo", LO, 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
